// File: rtl/idct_transpose_buf_pkg.sv
// Shared IDCT constants: coefficient width, block dimension and the column-stage
// input permutation used when a transposed column is handed on.
package idct_transpose_buf_pkg;

  localparam int unsigned CoefW  = 32;
  localparam int unsigned BlkDim = 8;
  localparam int unsigned IdxW   = 3;

  typedef logic [IdxW-1:0] idx_t;

  // Output slot k of a column carries row ColPerm[k].
  localparam idx_t ColPerm [BlkDim] = '{3'd0, 3'd4, 3'd6, 3'd2, 3'd1, 3'd7, 3'd5, 3'd3};

  function automatic idx_t perm_row(input idx_t slot);
    return ColPerm[slot];
  endfunction

endpackage

// File: rtl/idct_transpose_buf_tbuf_bank.sv
// One 8x8 coefficient bank: written a row at a time, read a column at a time with
// the column-stage row permutation applied on the read port.
module idct_transpose_buf_tbuf_bank
  import idct_transpose_buf_pkg::*;
#(
  parameter int unsigned Width = CoefW
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             we_i,
  input  idx_t             wr_row_i,
  input  logic [Width-1:0] wr_data_i [BlkDim],
  input  idx_t             rd_col_i,
  output logic [Width-1:0] rd_data_o [BlkDim]
);

  logic [Width-1:0] mem_q [BlkDim][BlkDim];

  // Cleared on reset so the read mux shows zeros before the first block lands.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int r = 0; r < BlkDim; r++) begin
        for (int c = 0; c < BlkDim; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else if (we_i) begin
      for (int c = 0; c < BlkDim; c++) begin
        mem_q[wr_row_i][c] <= wr_data_i[c];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < BlkDim; k++) begin
      rd_data_o[k] = mem_q[perm_row(idx_t'(k))][rd_col_i];
    end
  end

endmodule

// File: rtl/idct_transpose_buf.sv
// Row-to-column transpose buffer between the IDCT passes. Define IDCT_TBUF_PINGPONG_EN
// for two banks (write of block k+1 overlaps read of block k); otherwise one bank.
module idct_transpose_buf
  import idct_transpose_buf_pkg::*;
#(
  parameter int unsigned DW = CoefW
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          row_valid_i,
  output logic          row_ready_o,
  input  logic [DW-1:0] row_d0_i,
  input  logic [DW-1:0] row_d1_i,
  input  logic [DW-1:0] row_d2_i,
  input  logic [DW-1:0] row_d3_i,
  input  logic [DW-1:0] row_d4_i,
  input  logic [DW-1:0] row_d5_i,
  input  logic [DW-1:0] row_d6_i,
  input  logic [DW-1:0] row_d7_i,
  output logic          col_valid_o,
  input  logic          col_ready_i,
  output logic [2:0]    col_idx_o,
  output logic [DW-1:0] out0_o,
  output logic [DW-1:0] out1_o,
  output logic [DW-1:0] out2_o,
  output logic [DW-1:0] out3_o,
  output logic [DW-1:0] out4_o,
  output logic [DW-1:0] out5_o,
  output logic [DW-1:0] out6_o,
  output logic [DW-1:0] out7_o,
  output logic          blk_done_o
);

`ifdef IDCT_TBUF_PINGPONG_EN
  localparam int unsigned NBank = 2;
`else
  localparam int unsigned NBank = 1;
`endif

  // Flag/pointer state is always sized for two banks; without ping-pong the bank
  // pointers never leave 0 and flag 1 is never set.
  logic [1:0] full_q, full_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  idx_t       wr_row_q, wr_row_d;
  idx_t       rd_col_q, rd_col_d;
  logic       blk_done_q, blk_done_d;

  logic       row_ready, col_valid;
  logic       wr_acc, rd_acc, wr_last, rd_last;

  logic [DW-1:0] row_data [BlkDim];
  logic [DW-1:0] bank_rd  [2][BlkDim];

  assign row_data = '{row_d0_i, row_d1_i, row_d2_i, row_d3_i,
                      row_d4_i, row_d5_i, row_d6_i, row_d7_i};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    if (b < NBank) begin : g_inst
      idct_transpose_buf_tbuf_bank #(
        .Width (DW)
      ) u_bank (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .we_i      (wr_acc && (wr_bank_q == 1'(b))),
        .wr_row_i  (wr_row_q),
        .wr_data_i (row_data),
        .rd_col_i  (rd_col_q),
        .rd_data_o (bank_rd[b])
      );
    end else begin : g_tie
      for (genvar k = 0; k < BlkDim; k++) begin : g_zero
        assign bank_rd[b][k] = '0;
      end
    end
  end

  always_comb begin
    row_ready  = !full_q[wr_bank_q];
    col_valid  = full_q[rd_bank_q];
    wr_acc     = row_valid_i && row_ready;
    rd_acc     = col_valid && col_ready_i;
    wr_last    = (wr_row_q == idx_t'(BlkDim - 1));
    rd_last    = (rd_col_q == idx_t'(BlkDim - 1));

    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_row_d   = wr_row_q;
    rd_col_d   = rd_col_q;
    blk_done_d = 1'b0;

    if (wr_acc) begin
      wr_row_d = wr_row_q + idx_t'(1);
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
`ifdef IDCT_TBUF_PINGPONG_EN
        wr_bank_d = ~wr_bank_q;
`endif
      end
    end

    // A write completion and a read completion always target different banks here,
    // since a write needs the bank empty and a read needs it full.
    if (rd_acc) begin
      rd_col_d = rd_col_q + idx_t'(1);
      if (rd_last) begin
        full_d[rd_bank_q] = 1'b0;
        blk_done_d        = 1'b1;
`ifdef IDCT_TBUF_PINGPONG_EN
        rd_bank_d = ~rd_bank_q;
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_row_q   <= '0;
      rd_col_q   <= '0;
      blk_done_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_row_q   <= wr_row_d;
      rd_col_q   <= rd_col_d;
      blk_done_q <= blk_done_d;
    end
  end

  assign row_ready_o = row_ready;
  assign col_valid_o = col_valid;
  assign col_idx_o   = rd_col_q;
  assign blk_done_o  = blk_done_q;

  assign out0_o = bank_rd[rd_bank_q][0];
  assign out1_o = bank_rd[rd_bank_q][1];
  assign out2_o = bank_rd[rd_bank_q][2];
  assign out3_o = bank_rd[rd_bank_q][3];
  assign out4_o = bank_rd[rd_bank_q][4];
  assign out5_o = bank_rd[rd_bank_q][5];
  assign out6_o = bank_rd[rd_bank_q][6];
  assign out7_o = bank_rd[rd_bank_q][7];

endmodule
